tdpram_port_arbiter: RTL and testbench

- Shares one port of the dual-clock true dual-port RAM (its A or B side) between NUM_REQ requesters on that port's clock.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Registers the winning command onto the RAM port, then tags read data back to the issuing requester after the configured RAM read latency.
- Sits between client logic (DMA, host, DSP engines) and the RAM instance; the other RAM port stays available to another clock domain.

---
 rtl/tdpram_port_arb_pkg.sv | 29 ++
 rtl/tdpram_rr_pick.sv | 62 ++++++
 rtl/tdpram_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_tdpram_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdpram_port_arb_pkg.sv
// ---------------------------------------------------------------------------
// tdpram_port_arb_pkg
// Shared types, constants and helpers for the RAM port arbiter.
//   NUM_REQ_MAX        largest supported requester count
//   RD_LATENCY_NOREG   RAM read latency without output register
//   RD_LATENCY_OUTREG  RAM read latency with output register
//   req_vec_t          one-hot requester vector, NUM_REQ_MAX wide
//   onehot_to_idx      encodes a one-hot requester vector to its index
// ---------------------------------------------------------------------------
package tdpram_port_arb_pkg;

   localparam int NUM_REQ_MAX       = 8;
   localparam int IDX_MAX_W         = $clog2(NUM_REQ_MAX);
   localparam int RD_LATENCY_NOREG  = 1;
   localparam int RD_LATENCY_OUTREG = 2;

   typedef logic [NUM_REQ_MAX-1:0] req_vec_t;

   // OR-reduction encoder; the input is expected to carry at most one set bit.
   function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input req_vec_t oh);
      logic [IDX_MAX_W-1:0] idx;
      idx = {IDX_MAX_W{1'b0}};
      for (int i = 0; i < NUM_REQ_MAX; i++) begin
         idx = idx | (oh[i] ? IDX_MAX_W'(i) : {IDX_MAX_W{1'b0}});
      end
      return idx;
   endfunction

endpackage

// File: rtl/tdpram_rr_pick.sv
// ---------------------------------------------------------------------------
// tdpram_rr_pick
// Combinational round-robin picker: rotate the request vector so the
// requester after LAST is at bit 0, find the lowest set bit, rotate back.
//   REQ_I        per-requester valid
//   LAST_I       index of the most recently granted requester
//   EN_I         0 suppresses every grant
//   GRANT_O      one-hot grant (all zero when nothing is granted)
//   GRANT_IDX_O  index of the picked requester (meaningful only with a grant)
// ---------------------------------------------------------------------------
module tdpram_rr_pick
   import tdpram_port_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ >= 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] REQ_I,
   input  logic [IDX_W-1:0]   LAST_I,
   input  logic               EN_I,
   output logic [NUM_REQ-1:0] GRANT_O,
   output logic [IDX_W-1:0]   GRANT_IDX_O
);

   // Positions never exceed 2*NUM_REQ-1, so a single conditional subtract wraps them.
   function automatic logic [IDX_W-1:0] wrap_idx(input int pos);
      int w;
      if (pos >= NUM_REQ) begin
         w = pos - NUM_REQ;
      end else begin
         w = pos;
      end
      return IDX_W'(w);
   endfunction

   req_vec_t             rot_s;
   req_vec_t             first_s;
   logic [IDX_MAX_W-1:0] pick_s;
   logic [IDX_W-1:0]     idx_s;

   // Rotate the requests so that requester LAST+1 lands on bit 0
   always_comb begin
      rot_s = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         rot_s[j] = REQ_I[wrap_idx(int'(LAST_I) + 1 + j)];
      end
   end

   // Lowest set bit of the rotated vector, mapped back to an absolute index
   always_comb begin
      first_s = rot_s & (~rot_s + req_vec_t'(1'b1));
      pick_s  = onehot_to_idx(first_s);
      idx_s   = wrap_idx(int'(LAST_I) + 1 + int'(pick_s));
      GRANT_O = '0;
      if (EN_I && (rot_s != '0)) begin
         GRANT_O[idx_s] = 1'b1;
      end else begin
         GRANT_O = '0;
      end
      GRANT_IDX_O = idx_s;
   end

endmodule

// File: rtl/tdpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tdpram_port_arbiter
// Shares one port of a true dual-port RAM between NUM_REQ requesters.
// Round-robin grant is combinational; the winning command is registered onto
// the RAM port, and a one-hot tag pipeline routes read data back.
//   CLK_I / RST_I        port clock, asynchronous active-high reset
//   ARB_EN_I             0 blocks new grants (in-flight reads still finish)
//   REQ_VALID_I/WEN_I    per-requester command valid and write/read select
//   REQ_ADDR_I/DATA_I    packed per-requester address and write data
//   REQ_READY_O          one-hot grant
//   RSP_VALID_O          one-hot read-response strobe
//   RSP_DATA_O           read data (RAM_DOUT_I passed through)
//   RAM_WEN_O/ADDR_O/DIN_O  registered RAM command
//   RAM_DOUT_I           RAM read data
//   OUTSTANDING_O        reads issued whose response is not yet delivered
// ---------------------------------------------------------------------------
module tdpram_port_arbiter
   import tdpram_port_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 128,
   parameter int ADDR_WIDTH = (DEPTH >= 2) ? $clog2(DEPTH) : 1,
   parameter int NUM_REQ    = 4,
   parameter int RD_LATENCY = RD_LATENCY_NOREG
) (
   input  logic                          CLK_I,
   input  logic                          RST_I,
   input  logic                          ARB_EN_I,
   input  logic [NUM_REQ-1:0]            REQ_VALID_I,
   input  logic [NUM_REQ-1:0]            REQ_WEN_I,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR_I,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA_I,
   output logic [NUM_REQ-1:0]            REQ_READY_O,
   output logic [NUM_REQ-1:0]            RSP_VALID_O,
   output logic [DATA_WIDTH-1:0]         RSP_DATA_O,
   output logic                          RAM_WEN_O,
   output logic [ADDR_WIDTH-1:0]         RAM_ADDR_O,
   output logic [DATA_WIDTH-1:0]         RAM_DIN_O,
   input  logic [DATA_WIDTH-1:0]         RAM_DOUT_I,
   output logic [1:0]                    OUTSTANDING_O
);

   localparam int IDX_W = (NUM_REQ >= 2) ? $clog2(NUM_REQ) : 1;

   generate
      if ((RD_LATENCY != RD_LATENCY_NOREG) && (RD_LATENCY != RD_LATENCY_OUTREG)) begin : g_bad_latency
         $error("tdpram_port_arbiter: RD_LATENCY must be 1 or 2");
      end
      if ((NUM_REQ < 2) || (NUM_REQ > NUM_REQ_MAX)) begin : g_bad_num_req
         $error("tdpram_port_arbiter: NUM_REQ must be in 2..8");
      end
      if (DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
         $error("tdpram_port_arbiter: ADDR_WIDTH too small for DEPTH");
      end
   endgenerate

   logic [IDX_W-1:0]      last_r;
   logic [NUM_REQ-1:0]    grant_s;
   logic [IDX_W-1:0]      grant_idx_s;
   logic                  pick_en_s;
   logic                  hs_s;
   logic                  rd_hs_s;
   logic                  rsp_any_s;
   logic                  sel_wen_s;
   logic [ADDR_WIDTH-1:0] sel_addr_s;
   logic [DATA_WIDTH-1:0] sel_data_s;
   logic                  ram_wen_r;
   logic [ADDR_WIDTH-1:0] ram_addr_r;
   logic [DATA_WIDTH-1:0] ram_din_r;
   logic [NUM_REQ-1:0]    tag_r [RD_LATENCY+1];
   logic [1:0]            outstanding_r;

   // Reset is folded in so no grant is shown while RST_I is high.
   assign pick_en_s = ARB_EN_I & ~RST_I;

   tdpram_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .REQ_I       (REQ_VALID_I),
      .LAST_I      (last_r),
      .EN_I        (pick_en_s),
      .GRANT_O     (grant_s),
      .GRANT_IDX_O (grant_idx_s)
   );

   assign hs_s    = |(grant_s & REQ_VALID_I);
   assign rd_hs_s = hs_s & ~sel_wen_s;

   // AND-OR steer of the granted requester's command fields
   always_comb begin
      sel_wen_s  = 1'b0;
      sel_addr_s = '0;
      sel_data_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_wen_s  = sel_wen_s  | (grant_s[i] & REQ_WEN_I[i]);
         sel_addr_s = sel_addr_s | ({ADDR_WIDTH{grant_s[i]}} & REQ_ADDR_I[i*ADDR_WIDTH +: ADDR_WIDTH]);
         sel_data_s = sel_data_s | ({DATA_WIDTH{grant_s[i]}} & REQ_DATA_I[i*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // RAM command register: load on handshake, otherwise drop WEN and hold address/data
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         ram_wen_r  <= 1'b0;
         ram_addr_r <= '0;
         ram_din_r  <= '0;
      end else if (hs_s) begin
         ram_wen_r  <= sel_wen_s;
         ram_addr_r <= sel_addr_s;
         ram_din_r  <= sel_data_s;
      end else begin
         ram_wen_r  <= 1'b0;
      end
   end

   // Round-robin pointer; reset value gives requester 0 top priority
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         last_r <= IDX_W'(NUM_REQ - 1);
      end else if (hs_s) begin
         last_r <= grant_idx_s;
      end else begin
         last_r <= last_r;
      end
   end

   // Read tag pipeline: stage 0 captures the reader, the last stage is the response strobe
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         for (int k = 0; k <= RD_LATENCY; k++) begin
            tag_r[k] <= '0;
         end
      end else begin
         tag_r[0] <= rd_hs_s ? grant_s : '0;
         for (int k = 1; k <= RD_LATENCY; k++) begin
            tag_r[k] <= tag_r[k-1];
         end
      end
   end

   assign rsp_any_s = |tag_r[RD_LATENCY];

   // Reads in flight: up on a read handshake, down on a delivered response
   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         outstanding_r <= 2'd0;
      end else begin
         case ({rd_hs_s, rsp_any_s})
            2'b10:   outstanding_r <= outstanding_r + 2'd1;
            2'b01:   outstanding_r <= outstanding_r - 2'd1;
            default: outstanding_r <= outstanding_r;
         endcase
      end
   end

   assign REQ_READY_O   = grant_s;
   assign RSP_VALID_O   = tag_r[RD_LATENCY];
   assign RSP_DATA_O    = RAM_DOUT_I;
   assign RAM_WEN_O     = ram_wen_r;
   assign RAM_ADDR_O    = ram_addr_r;
   assign RAM_DIN_O     = ram_din_r;
   assign OUTSTANDING_O = outstanding_r;

endmodule

// File: tb/tb_tdpram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tdpram_port_arbiter
// Directed bench: one arbiter with RD_LATENCY=1 and one with RD_LATENCY=2
// share the same request stimulus, each backed by a small RAM model.
// ---------------------------------------------------------------------------
module tb_tdpram_port_arbiter;

   localparam int AW = 7;
   localparam int DW = 8;
   localparam int NR = 4;

   logic           clk;
   logic           rst;
   logic           arb_en;
   logic [NR-1:0]  v;
   logic [NR-1:0]  wen;
   logic [NR*AW-1:0] addr;
   logic [NR*DW-1:0] data;

   logic [NR-1:0] rdy1, rsp1, rdy2, rsp2;
   logic [DW-1:0] rdat1, rdin1, rdout1, rdat2, rdin2, rdout2;
   logic [AW-1:0] raddr1, raddr2;
   logic          rwen1, rwen2;
   logic [1:0]    outs1, outs2;

   logic [DW-1:0] mem1 [128];
   logic [DW-1:0] mem2 [128];
   logic [DW-1:0] q1_r, q2a_r, q2b_r;

   int n_chk;
   int n_bad;

   logic [3:0] exp_g   [5];
   logic [3:0] exp_rsp [5];
   logic [1:0] exp_out [5];
   logic [7:0] exp_d   [5];
   logic [4:0] pat;
   logic [3:0] alt_g   [4];

   tdpram_port_arbiter #(.DATA_WIDTH(DW), .DEPTH(128), .NUM_REQ(NR), .RD_LATENCY(1)) u_dut1 (
      .CLK_I(clk), .RST_I(rst), .ARB_EN_I(arb_en),
      .REQ_VALID_I(v), .REQ_WEN_I(wen), .REQ_ADDR_I(addr), .REQ_DATA_I(data),
      .REQ_READY_O(rdy1), .RSP_VALID_O(rsp1), .RSP_DATA_O(rdat1),
      .RAM_WEN_O(rwen1), .RAM_ADDR_O(raddr1), .RAM_DIN_O(rdin1), .RAM_DOUT_I(rdout1),
      .OUTSTANDING_O(outs1)
   );

   tdpram_port_arbiter #(.DATA_WIDTH(DW), .DEPTH(128), .NUM_REQ(NR), .RD_LATENCY(2)) u_dut2 (
      .CLK_I(clk), .RST_I(rst), .ARB_EN_I(arb_en),
      .REQ_VALID_I(v), .REQ_WEN_I(wen), .REQ_ADDR_I(addr), .REQ_DATA_I(data),
      .REQ_READY_O(rdy2), .RSP_VALID_O(rsp2), .RSP_DATA_O(rdat2),
      .RAM_WEN_O(rwen2), .RAM_ADDR_O(raddr2), .RAM_DIN_O(rdin2), .RAM_DOUT_I(rdout2),
      .OUTSTANDING_O(outs2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM behind the latency-1 arbiter (no output register)
   always @(posedge clk) begin
      if (rwen1) mem1[raddr1] <= rdin1;
      q1_r <= mem1[raddr1];
   end
   assign rdout1 = q1_r;

   // RAM behind the latency-2 arbiter (with output register)
   always @(posedge clk) begin
      if (rwen2) mem2[raddr2] <= rdin2;
      q2a_r <= mem2[raddr2];
      q2b_r <= q2a_r;
   end
   assign rdout2 = q2b_r;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic vv, input logic ww,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      v[i]             = vv;
      wen[i]           = ww;
      addr[i*AW +: AW] = a;
      data[i*DW +: DW] = d;
   endtask

   task automatic clear_reqs();
      v    = '0;
      wen  = '0;
      addr = '0;
      data = '0;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      arb_en = 1'b1;
      clear_reqs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_bad = 0;
      for (int i = 0; i < 128; i++) begin
         mem1[i] = 8'(i * 3 + 7);
         mem2[i] = 8'(i * 3 + 7);
      end
      exp_g   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_rsp = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100};
      exp_out = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2};
      exp_d   = '{8'h00, 8'h00, 8'h37, 8'h3A, 8'h3D};
      pat     = 5'b01101;
      alt_g   = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};

      rst    = 1'b1;
      arb_en = 1'b1;
      clear_reqs();
      #1;
      check_val("rst_ready",   32'(rdy2),   32'h0);
      check_val("rst_rsp",     32'(rsp2),   32'h0);
      check_val("rst_wen",     32'(rwen2),  32'h0);
      check_val("rst_addr",    32'(raddr2), 32'h0);
      check_val("rst_din",     32'(rdin2),  32'h0);
      check_val("rst_outs",    32'(outs2),  32'h0);
      check_val("rst_outs_l1", 32'(outs1),  32'h0);

      // All four read, latency 1: rotating grants and tagged responses
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(16 + i), 8'h00);
      for (int k = 0; k < 5; k++) begin
         #1;
         check_val($sformatf("rr_grant%0d", k), 32'(rdy1), 32'(exp_g[k]));
         check_val($sformatf("rr_rsp%0d", k),   32'(rsp1), 32'(exp_rsp[k]));
         check_val($sformatf("rr_outs%0d", k),  32'(outs1), 32'(exp_out[k]));
         if (exp_rsp[k] != 4'b0000) check_val($sformatf("rr_data%0d", k), 32'(rdat1), 32'(exp_d[k]));
         tick();
      end
      clear_reqs();
      repeat (4) tick();
      check_val("rr_drain_outs", 32'(outs1), 32'h0);

      // Write then read same address, latency 2
      do_reset();
      set_req(2, 1'b1, 1'b1, 7'h05, 8'hA5);
      #1;
      check_val("rw_grant_w", 32'(rdy2), 32'b0100);
      tick();
      set_req(2, 1'b0, 1'b0, 7'h00, 8'h00);
      set_req(1, 1'b1, 1'b0, 7'h05, 8'h00);
      #1;
      check_val("rw_grant_r", 32'(rdy2),   32'b0010);
      check_val("rw_ram_wen", 32'(rwen2),  32'h1);
      check_val("rw_ram_adr", 32'(raddr2), 32'h05);
      check_val("rw_ram_din", 32'(rdin2),  32'hA5);
      tick();
      clear_reqs();
      #1;
      check_val("rw_outs_a",  32'(outs2), 32'h1);
      check_val("rw_wen_off", 32'(rwen2), 32'h0);
      tick();
      #1;
      check_val("rw_rsp_early", 32'(rsp2),  32'h0);
      check_val("rw_outs_b",    32'(outs2), 32'h1);
      tick();
      #1;
      check_val("rw_rsp",    32'(rsp2),  32'b0010);
      check_val("rw_data",   32'(rdat2), 32'hA5);
      check_val("rw_outs_c", 32'(outs2), 32'h1);
      tick();
      #1;
      check_val("rw_rsp_end",  32'(rsp2),  32'h0);
      check_val("rw_outs_end", 32'(outs2), 32'h0);

      // Lone requester 3 gets every cycle
      do_reset();
      for (int k = 0; k < 5; k++) begin
         set_req(3, 1'b1, pat[k], AW'(32 + k), 8'(8'hC0 + k));
         #1;
         check_val($sformatf("solo_grant%0d", k), 32'(rdy2), 32'b1000);
         tick();
         check_val($sformatf("solo_wen%0d", k),  32'(rwen2),  32'(pat[k]));
         check_val($sformatf("solo_addr%0d", k), 32'(raddr2), 32'(32 + k));
      end
      clear_reqs();
      repeat (4) tick();

      // Arbitration disabled holds the pointer
      set_req(1, 1'b1, 1'b0, 7'h01, 8'h00);
      #1;
      check_val("dis_pre_grant", 32'(rdy2), 32'b0010);
      tick();
      arb_en = 1'b0;
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, AW'(96 + i), 8'(8'h60 + i));
      for (int k = 0; k < 3; k++) begin
         #1;
         check_val($sformatf("dis_ready%0d", k), 32'(rdy2), 32'h0);
         tick();
         check_val($sformatf("dis_wen%0d", k), 32'(rwen2), 32'h0);
      end
      arb_en = 1'b1;
      #1;
      check_val("dis_resume", 32'(rdy2), 32'b0100);
      tick();
      check_val("dis_res_wen",  32'(rwen2),  32'h1);
      check_val("dis_res_addr", 32'(raddr2), 32'(96 + 2));
      clear_reqs();
      repeat (4) tick();

      // Asynchronous reset with two reads in flight
      do_reset();
      set_req(1, 1'b1, 1'b0, 7'h41, 8'h00);
      #1;
      check_val("ar_grant1", 32'(rdy2), 32'b0010);
      tick();
      set_req(1, 1'b0, 1'b0, 7'h00, 8'h00);
      set_req(2, 1'b1, 1'b0, 7'h42, 8'h00);
      tick();
      clear_reqs();
      #1;
      check_val("ar_outs_pre", 32'(outs2),  32'h2);
      check_val("ar_addr_pre", 32'(raddr2), 32'h42);
      #2;
      rst = 1'b1;
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, AW'(112 + i), 8'h00);
      #1;
      check_val("ar_ready", 32'(rdy2),   32'h0);
      check_val("ar_addr",  32'(raddr2), 32'h0);
      check_val("ar_outs",  32'(outs2),  32'h0);
      check_val("ar_rsp",   32'(rsp2),   32'h0);
      check_val("ar_wen",   32'(rwen2),  32'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_val("ar_first_grant", 32'(rdy2), 32'b0001);
      check_val("ar_rsp_rel",     32'(rsp2), 32'h0);
      tick();
      clear_reqs();
      for (int k = 0; k < 4; k++) begin
         #1;
         check_val($sformatf("ar_rsp_after%0d", k),  32'(rsp2),  32'h0);
         check_val($sformatf("ar_outs_after%0d", k), 32'(outs2), 32'h0);
         tick();
      end

      // Alternating writes never produce responses
      do_reset();
      set_req(0, 1'b1, 1'b1, 7'h50, 8'h11);
      set_req(1, 1'b1, 1'b1, 7'h51, 8'h22);
      for (int k = 0; k < 4; k++) begin
         #1;
         check_val($sformatf("wo_grant%0d", k), 32'(rdy2),  32'(alt_g[k]));
         check_val($sformatf("wo_rsp%0d", k),   32'(rsp2),  32'h0);
         check_val($sformatf("wo_outs%0d", k),  32'(outs2), 32'h0);
         tick();
      end
      clear_reqs();
      tick();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
